// File: rtl/pipe_pkg.sv
// Shared pipeline types: forward selects, result sources, shadow records.
// Imported by the hazard controller and its forwarding comparator.
package pipe_pkg;

    // Width of the register index held in the shadow records.
    localparam int RF_AW = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

    // Execute-stage record: sources for forwarding, dest for load-use.
    typedef struct packed {
        logic [RF_AW-1:0] rs1;
        logic [RF_AW-1:0] rs2;
        logic [RF_AW-1:0] rd;
        logic             regwrite;
        logic             is_load;
    } stage_rec_t;

    // Memory/Writeback record: only what the forwarding compare needs.
    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic             regwrite;
    } wr_rec_t;

    function automatic logic is_load_src(input logic [1:0] rsrc);
        logic r;
        r = 1'b0;
        unique case (rsrc)
            RS_MEM:         r = 1'b1;
            RS_ALU, RS_PC4: r = 1'b0;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Forward-select comparator for one Execute source operand.
// Ports: rs_e source index; rd_m/regwrite_m, rd_w/regwrite_w writers; sel out.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    output fwd_sel_t          sel
);

    logic hit_m;
    logic hit_w;

    // x0 is hardwired zero, so a write to it must never be forwarded.
    assign hit_m = regwrite_m && (rd_m != '0) && (rd_m == rs_e);
    assign hit_w = regwrite_w && (rd_w != '0) && (rd_w == rs_e);

    // Memory holds the younger result, so it wins over Writeback.
    always_comb begin
        sel = FWD_REG;
        if (hit_m) begin
            sel = FWD_MEM;
        end else if (hit_w) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline (F/D/E/M/W).
// In: Decode regs/flags, pcsrc_e. Out: forward selects, stall/flush, stall_count.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = RF_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic [1:0]        resultsrc_d,
    input  logic              pcsrc_e,
    output logic [1:0]        forward_srcA_e,
    output logic [1:0]        forward_srcB_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  stall_count
);

    stage_rec_t        e_q, e_d;
    wr_rec_t           m_q, m_d;
    wr_rec_t           w_q, w_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic     lwstall;
    logic     stall;
    logic     flush_e_i;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e       (e_q.rs1),
        .rd_m       (m_q.rd),
        .regwrite_m (m_q.regwrite),
        .rd_w       (w_q.rd),
        .regwrite_w (w_q.regwrite),
        .sel        (fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e       (e_q.rs2),
        .rd_m       (m_q.rd),
        .regwrite_m (m_q.regwrite),
        .rd_w       (w_q.rd),
        .regwrite_w (w_q.regwrite),
        .sel        (fwd_b)
    );

    // A load in Execute has no data until Writeback, so a Decode reader
    // must wait one cycle; x0 readers never need to wait.
    always_comb begin
        lwstall = e_q.is_load && (e_q.rd != '0) &&
                  ((use_rs1_d && (rs1_d == e_q.rd)) ||
                   (use_rs2_d && (rs2_d == e_q.rd)));
    end

    // A taken branch squashes the stalled instruction anyway, so flush
    // dominates; everything is held quiet while in reset.
    always_comb begin
        stall     = reset_n && lwstall && !pcsrc_e;
        flush_e_i = reset_n && (lwstall || pcsrc_e);
    end

    always_comb begin
        e_d = '0;
        if (!flush_e_i) begin
            e_d.rs1      = rs1_d;
            e_d.rs2      = rs2_d;
            e_d.rd       = rd_d;
            e_d.regwrite = regwrite_d;
            e_d.is_load  = is_load_src(resultsrc_d);
        end

        m_d.rd       = e_q.rd;
        m_d.regwrite = e_q.regwrite;
        w_d          = m_q;

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e_q           <= '0;
            m_q           <= '0;
            w_q           <= '0;
            stall_count_q <= '0;
        end else begin
            e_q           <= e_d;
            m_q           <= m_d;
            w_q           <= w_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign forward_srcA_e = fwd_a;
    assign forward_srcB_e = fwd_b;
    assign stall_f        = stall;
    assign stall_d        = stall;
    assign flush_d        = reset_n && pcsrc_e;
    assign flush_e        = flush_e_i;
    assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, flush, reset.
// Inputs change 1ns after the rising edge; outputs are checked before the next.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset_n;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic        use_rs1_d;
    logic        use_rs2_d;
    logic [4:0]  rd_d;
    logic        regwrite_d;
    logic [1:0]  resultsrc_d;
    logic        pcsrc_e;
    logic [1:0]  forward_srcA_e;
    logic [1:0]  forward_srcB_e;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        flush_e;
    logic [31:0] stall_count;

    int n_chk = 0;
    int n_err = 0;

    hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .use_rs1_d      (use_rs1_d),
        .use_rs2_d      (use_rs2_d),
        .rd_d           (rd_d),
        .regwrite_d     (regwrite_d),
        .resultsrc_d    (resultsrc_d),
        .pcsrc_e        (pcsrc_e),
        .forward_srcA_e (forward_srcA_e),
        .forward_srcB_e (forward_srcB_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic sf, input logic sd,
                       input logic fd, input logic fe);
        chk({tag, ".stall_f"}, {31'b0, stall_f}, {31'b0, sf});
        chk({tag, ".stall_d"}, {31'b0, stall_d}, {31'b0, sd});
        chk({tag, ".flush_d"}, {31'b0, flush_d}, {31'b0, fd});
        chk({tag, ".flush_e"}, {31'b0, flush_e}, {31'b0, fe});
    endtask

    task automatic fwd(input string tag, input logic [1:0] a,
                       input logic [1:0] b);
        chk({tag, ".fwdA"}, {30'b0, forward_srcA_e}, {30'b0, a});
        chk({tag, ".fwdB"}, {30'b0, forward_srcB_e}, {30'b0, b});
    endtask

    task automatic drv(input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rsrc);
        rs1_d       = r1;
        rs2_d       = r2;
        use_rs1_d   = u1;
        use_rs2_d   = u2;
        rd_d        = rd;
        regwrite_d  = rw;
        resultsrc_d = rsrc;
        #1;
    endtask

    task automatic nop();
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        pcsrc_e = 1'b0;
        nop();
        step();
        step();
        reset_n = 1'b1;
        nop();
        fwd("reset", 2'b00, 2'b00);
        ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.count", stall_count, 32'd0);

        // add x5,x1,x2 ; add x6,x5,x7
        drv(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00);
        step();
        drv(5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 2'b00);
        ctl("b2b.d", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        nop();
        fwd("b2b.e", 2'b10, 2'b00);
        step();
        fwd("b2b.nop", 2'b00, 2'b00);

        // add x5 ; nop ; sub x8,x9,x5
        drv(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00);
        step();
        nop();
        step();
        drv(5'd9, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 2'b00);
        step();
        drv(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00);
        fwd("wb.sub", 2'b00, 2'b01);

        // add x5 ; add x5 ; add x10,x5,x5 -> M wins over W
        step();
        drv(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00);
        step();
        drv(5'd5, 5'd5, 1'b1, 1'b1, 5'd10, 1'b1, 2'b00);
        step();
        nop();
        fwd("prio", 2'b10, 2'b10);
        step();
        step();
        step();

        // lw x5,0(x1) ; add x6,x5,x0
        chk("lu.count0", stall_count, 32'd0);
        drv(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01);
        step();
        drv(5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 2'b00);
        ctl("lu.stall", 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        ctl("lu.after", 1'b0, 1'b0, 1'b0, 1'b0);
        fwd("lu.bubble", 2'b00, 2'b00);
        chk("lu.count1", stall_count, 32'd1);
        step();
        nop();
        fwd("lu.fwd", 2'b01, 2'b00);
        chk("lu.count1b", stall_count, 32'd1);
        step();

        // add x0 ; add x7,x0,x0 ; lw x0 ; add x9,x0,x0
        drv(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 2'b00);
        step();
        drv(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 2'b00);
        step();
        drv(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b01);
        fwd("x0.rd", 2'b00, 2'b00);
        step();
        drv(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 2'b00);
        ctl("x0.lw", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        nop();
        fwd("x0.rd2", 2'b00, 2'b00);
        step();

        // lw x5 ; add x6,x5 with branch taken in the same cycle
        drv(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01);
        step();
        drv(5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 2'b00);
        pcsrc_e = 1'b1;
        #1;
        ctl("br.lu", 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        pcsrc_e = 1'b0;
        nop();
        chk("br.count", stall_count, 32'd1);
        fwd("br.bubble", 2'b00, 2'b00);
        step();

        // add x5 ; lw x6,0(x5) ; add x7,x6 then reset with branch taken
        drv(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00);
        step();
        drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 2'b01);
        step();
        drv(5'd6, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 2'b00);
        fwd("rst.pre", 2'b10, 2'b00);
        ctl("rst.pre", 1'b1, 1'b1, 1'b0, 1'b1);
        reset_n = 1'b0;
        pcsrc_e = 1'b1;
        #1;
        ctl("rst.in", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        pcsrc_e = 1'b0;
        nop();
        fwd("rst.post", 2'b00, 2'b00);
        chk("rst.count", stall_count, 32'd0);
        ctl("rst.post", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
